// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
//   Arbitrates two command requesters onto a single RAM command port.
//   An address command (wr-addr / rd-addr) locks the RAM to its requester
//   until that requester sends the matching data phase, or until the owner
//   has been idle for LOCK_TIMEOUT cycles. A rd-data command waits for the
//   RAM's read data and routes it back to the requester that issued it.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req0_cmd / req1_cmd    command word: [9:8] opcode, [7:0] payload
//   req0_valid/req1_valid  command present
//   req0_ready/req1_ready  command accepted when valid && ready (combinational)
//   ram_din, ram_rx_valid  registered command and one-cycle strobe to the RAM
//   ram_dout, ram_tx_valid read data from the RAM and its qualifier
//   rsp0_* / rsp1_*        per-requester read data and one-cycle strobe
//   rsp_err                one-cycle strobe: expected read data was missing
//   lock_owner             00 none, 01 req0, 10 req1 (registered)
module ram_cmd_arbiter #(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req0_cmd,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [9:0] req1_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic [7:0] rsp0_data,
    output logic       rsp0_valid,
    output logic [7:0] rsp1_data,
    output logic       rsp1_valid,
    output logic       rsp_err,
    output logic [1:0] lock_owner
);

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Last stall count before the lock is released.
    localparam logic [7:0] TMO_LAST = 8'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic       owner, owner_nx;     // lock owner / pending reader: 0 req0, 1 req1
    logic       prio, prio_nx;       // requester that wins a tie in IDLE
    logic [7:0] tcnt, tcnt_nx;       // owner stall counter in LOCKED
    logic       wcnt, wcnt_nx;       // cycles spent in WAIT_RSP
    logic       grant;               // a command is accepted this cycle
    logic       gsel;                // which requester is accepted
    logic [1:0] op;                  // opcode of the accepted command
    logic       rsp_take;            // read data is sampled this cycle
    logic [1:0] lock_nx;

    logic [CMD_W-1:0] cmd_p1;
    logic             vld_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            tcnt  <= '0;
            wcnt  <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            prio  <= prio_nx;
            tcnt  <= tcnt_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        prio_nx    = prio;
        tcnt_nx    = tcnt;
        wcnt_nx    = wcnt;
        grant      = 1'b0;
        gsel       = 1'b0;
        op         = OP_WR_ADDR;
        rsp_take   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !prio)) begin
                    grant = 1'b1;
                    gsel  = 1'b0;
                end else if (req1_valid) begin
                    grant = 1'b1;
                    gsel  = 1'b1;
                end
                req0_ready = grant && !gsel;
                req1_ready = grant && gsel;
                if (grant) begin
                    op       = gsel ? req1_cmd[9:8] : req0_cmd[9:8];
                    prio_nx  = ~gsel;
                    owner_nx = gsel;
                    tcnt_nx  = '0;
                    wcnt_nx  = 1'b0;
                    case (op)
                        OP_WR_ADDR, OP_RD_ADDR: state_nx = LOCKED;
                        OP_RD_DATA:             state_nx = WAIT_RSP;
                        default:                state_nx = IDLE;
                    endcase
                end
            end
            LOCKED: begin
                // Owner is ready regardless of its valid; the other side waits.
                gsel       = owner;
                req0_ready = !owner;
                req1_ready = owner;
                grant      = owner ? req1_valid : req0_valid;
                if (grant) begin
                    op = owner ? req1_cmd[9:8] : req0_cmd[9:8];
                    case (op)
                        OP_WR_DATA: state_nx = IDLE;
                        OP_RD_DATA: begin
                            state_nx = WAIT_RSP;
                            wcnt_nx  = 1'b0;
                        end
                        default:    tcnt_nx = '0;
                    endcase
                end else if (tcnt == TMO_LAST) begin
                    state_nx = IDLE;
                    tcnt_nx  = '0;
                end else begin
                    tcnt_nx = tcnt + 8'd1;
                end
            end
            WAIT_RSP: begin
                // First cycle: command is on the RAM port. Second: RAM answers.
                if (wcnt) begin
                    rsp_take = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        case (state_nx)
            LOCKED, WAIT_RSP: lock_nx = {owner_nx, ~owner_nx};
            default:          lock_nx = 2'b00;
        endcase
    end

    // ---- stage p1: command register towards the RAM, responses, lock status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_p1     <= '0;
            vld_p1     <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_err    <= 1'b0;
            lock_owner <= 2'b00;
        end else begin
            vld_p1 <= grant;
            if (grant) begin
                cmd_p1 <= gsel ? req1_cmd : req0_cmd;
            end
            rsp0_valid <= rsp_take && ram_tx_valid && !owner;
            rsp1_valid <= rsp_take && ram_tx_valid && owner;
            rsp_err    <= rsp_take && !ram_tx_valid;
            if (rsp_take && ram_tx_valid && !owner) begin
                rsp0_data <= ram_dout[DATA_W-1:0];
            end
            if (rsp_take && ram_tx_valid && owner) begin
                rsp1_data <= ram_dout[DATA_W-1:0];
            end
            lock_owner <= lock_nx;
        end
    end

    assign ram_din      = cmd_p1;
    assign ram_rx_valid = vld_p1;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
module tb_ram_cmd_arbiter;

    localparam int LOCK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req0_cmd = '0;
    logic [9:0] req1_cmd = '0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_valid, rsp1_valid, rsp_err;
    logic [1:0] lock_owner;

    ram_cmd_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid),
        .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid),
        .rsp_err(rsp_err), .lock_owner(lock_owner)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: who holds the lock, who waits for read data
    // and at which clock edge that data is due, plus the expected outputs.
    int         m_owner  = -1;
    int         m_stall  = 0;
    int         m_prio   = 0;
    int         m_rd_req = -1;
    int         m_rd_due = 0;
    int         m_edge   = 0;
    bit         armed    = 0;
    int         w;
    bit         acc;
    logic [9:0] c;
    logic [9:0] e_din  = '0;
    logic       e_rxv  = 1'b0;
    logic [7:0] e_d0   = '0;
    logic [7:0] e_d1   = '0;
    logic       e_v0   = 1'b0;
    logic       e_v1   = 1'b0;
    logic       e_err  = 1'b0;
    logic [1:0] e_lock = '0;

    function automatic int winner();
        if (m_rd_req >= 0) return -1;
        if (m_owner >= 0) return m_owner;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] code(input int who);
        if (who == 0) return 2'b01;
        if (who == 1) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        w = winner();
        if (armed) begin
            chk("ram_din", ram_din, e_din);
            chk("ram_rx_valid", ram_rx_valid, e_rxv);
            chk("rsp0_data", rsp0_data, e_d0);
            chk("rsp1_data", rsp1_data, e_d1);
            chk("rsp0_valid", rsp0_valid, e_v0);
            chk("rsp1_valid", rsp1_valid, e_v1);
            chk("rsp_err", rsp_err, e_err);
            chk("lock_owner", lock_owner, e_lock);
            chk("req0_ready", req0_ready, (w == 0));
            chk("req1_ready", req1_ready, (w == 1));
        end
        if (!rst_n) begin
            armed = 1; m_owner = -1; m_stall = 0; m_prio = 0; m_rd_req = -1;
            e_din = '0; e_rxv = 0; e_d0 = '0; e_d1 = '0;
            e_v0 = 0; e_v1 = 0; e_err = 0; e_lock = '0;
        end else if (armed) begin
            m_edge++;
            e_rxv = 0; e_v0 = 0; e_v1 = 0; e_err = 0;
            acc = (w == 0 && req0_valid) || (w == 1 && req1_valid);
            c   = (w == 1) ? req1_cmd : req0_cmd;
            if (m_rd_req >= 0) begin
                if (m_edge == m_rd_due) begin
                    if (ram_tx_valid) begin
                        if (m_rd_req == 0) begin e_v0 = 1; e_d0 = ram_dout; end
                        else begin e_v1 = 1; e_d1 = ram_dout; end
                    end else begin
                        e_err = 1;
                    end
                    m_rd_req = -1;
                end
            end else if (acc) begin
                e_din = c;
                e_rxv = 1;
                if (m_owner < 0) m_prio = 1 - w;
                case (c[9:8])
                    2'b00, 2'b10: begin m_owner = w; m_stall = 0; end
                    2'b01: m_owner = -1;
                    default: begin m_owner = -1; m_rd_req = w; m_rd_due = m_edge + 2; end
                endcase
            end else if (m_owner >= 0) begin
                m_stall++;
                if (m_stall == LOCK_TIMEOUT) m_owner = -1;
            end
            e_lock = (m_rd_req >= 0) ? code(m_rd_req) : code(m_owner);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst lock_owner", lock_owner, 2'b00);
        chk("rst ram_rx_valid", ram_rx_valid, 1'b0);
        chk("rst ram_din", ram_din, 10'h000);
        chk("rst rsp0_data", rsp0_data, 8'h00);
        chk("rst rsp_err", rsp_err, 1'b0);
        rst_n = 1;

        // Write: address then data, one strobe each
        req0_valid = 1; req0_cmd = 10'h012;
        tick(1);
        chk("wr addr din", ram_din, 10'h012);
        chk("wr addr strobe", ram_rx_valid, 1'b1);
        chk("wr addr lock", lock_owner, 2'b01);
        req0_cmd = 10'h1AB;
        tick(1);
        chk("wr data din", ram_din, 10'h1AB);
        chk("wr data strobe", ram_rx_valid, 1'b1);
        chk("wr data lock", lock_owner, 2'b00);
        req0_valid = 0;
        tick(1);
        chk("strobe single", ram_rx_valid, 1'b0);

        // Round-robin after a fresh reset
        rst_n = 0; tick(1); rst_n = 1;
        req0_valid = 1; req0_cmd = 10'h010;
        req1_valid = 1; req1_cmd = 10'h220;
        #1;
        chk("tie0 req0_ready", req0_ready, 1'b1);
        chk("tie0 req1_ready", req1_ready, 1'b0);
        tick(1);
        chk("tie0 din", ram_din, 10'h010);
        chk("locked req1_ready", req1_ready, 1'b0);
        req0_cmd = 10'h111;
        tick(1);
        chk("rel din", ram_din, 10'h111);
        chk("rel lock", lock_owner, 2'b00);
        req0_cmd = 10'h030;
        #1;
        chk("tie1 req1_ready", req1_ready, 1'b1);
        chk("tie1 req0_ready", req0_ready, 1'b0);
        tick(1);
        chk("tie1 din", ram_din, 10'h220);
        chk("tie1 lock", lock_owner, 2'b10);
        req1_cmd = 10'h144;
        tick(1);
        chk("tie1 data din", ram_din, 10'h144);
        req0_valid = 0; req1_valid = 0;
        tick(1);

        // Locked read with data returned by the RAM
        req0_valid = 1; req0_cmd = 10'h212;
        tick(1);
        chk("rd addr lock", lock_owner, 2'b01);
        req0_cmd = 10'h300;
        tick(1);
        chk("rd data din", ram_din, 10'h300);
        chk("rd pending lock", lock_owner, 2'b01);
        req0_valid = 0;
        tick(1);
        ram_tx_valid = 1; ram_dout = 8'h5A;
        tick(1);
        chk("rsp0_valid", rsp0_valid, 1'b1);
        chk("rsp0_data", rsp0_data, 8'h5A);
        chk("rsp1_valid quiet", rsp1_valid, 1'b0);
        chk("rsp lock free", lock_owner, 2'b00);
        ram_tx_valid = 0; ram_dout = 8'h00;
        tick(1);
        chk("rsp0_valid once", rsp0_valid, 1'b0);
        chk("rsp0_data held", rsp0_data, 8'h5A);

        // Lock timeout with req0 waiting
        req1_valid = 1; req1_cmd = 10'h040;
        tick(1);
        chk("tmo lock", lock_owner, 2'b10);
        req1_valid = 0; req0_valid = 1; req0_cmd = 10'h055;
        tick(15);
        chk("tmo still locked", lock_owner, 2'b10);
        chk("tmo req0 blocked", req0_ready, 1'b0);
        tick(1);
        chk("tmo released", lock_owner, 2'b00);
        chk("tmo no cmd", ram_rx_valid, 1'b0);
        chk("tmo req0_ready", req0_ready, 1'b1);
        tick(1);
        chk("tmo req0 din", ram_din, 10'h055);
        chk("tmo req0 lock", lock_owner, 2'b01);
        req0_cmd = 10'h166;
        tick(1);
        chk("tmo req0 data", ram_din, 10'h166);
        req0_valid = 0;

        // Missing read data from the RAM
        req1_valid = 1; req1_cmd = 10'h377;
        tick(1);
        chk("err din", ram_din, 10'h377);
        chk("err pending lock", lock_owner, 2'b10);
        req1_valid = 0; req0_valid = 1; req0_cmd = 10'h199;
        #1;
        chk("wait req0_ready", req0_ready, 1'b0);
        tick(2);
        chk("rsp_err", rsp_err, 1'b1);
        chk("err rsp1_valid", rsp1_valid, 1'b0);
        chk("err lock", lock_owner, 2'b00);
        tick(1);
        chk("rsp_err once", rsp_err, 1'b0);
        chk("after err din", ram_din, 10'h199);
        req0_valid = 0;
        tick(1);

        // Reset while waiting for read data
        req0_valid = 1; req0_cmd = 10'h310;
        tick(1);
        req0_valid = 0; rst_n = 0;
        tick(1);
        rst_n = 1; ram_tx_valid = 1; ram_dout = 8'hEE;
        tick(1);
        chk("abort rsp0_valid", rsp0_valid, 1'b0);
        chk("abort rsp_err", rsp_err, 1'b0);
        tick(2);
        chk("abort rsp0_valid late", rsp0_valid, 1'b0);
        chk("abort rsp0_data", rsp0_data, 8'h00);
        chk("abort rsp_err late", rsp_err, 1'b0);
        chk("abort lock", lock_owner, 2'b00);
        chk("abort din", ram_din, 10'h000);
        ram_tx_valid = 0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
